// File: rtl/sync_banked_ram.sv
// Byte-enabled single-clock RAM with write-first reads, 1- or 2-cycle read latency and a post-reset clear sweep.
// Define SYNC_BANKED_RAM_PARITY_EN to store one even-parity bit per byte and flag mismatches on read.
module sync_banked_ram #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int RD_PIPE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_par_flip,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                par_err,
  output logic                busy
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == CLEAR) begin
      if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
        state_nxt   = READY;
        clr_cnt_nxt = '0;
      end else begin
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
      end
    end
  end

  assign busy = (state == CLEAR);

  logic wr_in_range, rd_in_range, wr_ok, rd_ok, bypass;

  assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
  assign rd_in_range = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));
  assign wr_ok       = !busy && wr_en && wr_in_range;
  assign rd_ok       = !busy && rd_en;
  assign bypass      = wr_ok && (wr_addr == rd_addr);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; the clear sweep zeroes it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  logic [DATA_W-1:0] rd_word;
  logic              rd_perr;

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      for (int i = 0; i < NB; i++)
        if (bypass && wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

`ifdef SYNC_BANKED_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];

  // Stored bit is the even parity of the byte, inverted when injection is requested.
  always_ff @(posedge clk) begin
    if (busy) begin
      par_mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) par_mem[wr_addr][i] <= (^wr_data[8*i +: 8]) ^ wr_par_flip;
    end
  end

  logic [NB-1:0] ref_par;

  always_comb begin
    ref_par = '0;
    rd_perr = 1'b0;
    if (rd_in_range) begin
      ref_par = par_mem[rd_addr];
      for (int i = 0; i < NB; i++) begin
        if (bypass && wr_be[i]) ref_par[i] = (^wr_data[8*i +: 8]) ^ wr_par_flip;
        if ((^rd_word[8*i +: 8]) != ref_par[i]) rd_perr = 1'b1;
      end
    end
  end
`else
  logic unused_flip;
  assign unused_flip = wr_par_flip;
  assign rd_perr     = 1'b0;
`endif

  logic              stg_valid;
  logic [DATA_W-1:0] stg_data;
  logic              stg_err;

  generate
    if (RD_PIPE == 2) begin : g_pipe2
      logic              p_valid;
      logic [DATA_W-1:0] p_data;
      logic              p_err;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_valid <= 1'b0;
          p_data  <= '0;
          p_err   <= 1'b0;
        end else begin
          p_valid <= rd_ok;
          p_err   <= rd_ok && rd_perr;
          if (rd_ok) p_data <= rd_word;
        end
      end

      assign stg_valid = p_valid;
      assign stg_data  = p_data;
      assign stg_err   = p_err;
    end else begin : g_pipe1
      assign stg_valid = rd_ok;
      assign stg_data  = rd_word;
      assign stg_err   = rd_perr;
    end
  endgenerate

  // rd_data only moves on a completed read so it holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      par_err  <= 1'b0;
    end else begin
      rd_valid <= stg_valid;
      par_err  <= stg_valid && stg_err;
      if (stg_valid) rd_data <= stg_data;
    end
  end

endmodule

// File: tb/tb_sync_banked_ram.sv
// Self-checking bench: two instances (DEPTH 64 / latency 1 and DEPTH 48 / latency 2) share stimulus and are
// compared every cycle against an array-and-queue reference model, plus a directed vector table.
module tb_sync_banked_ram;

`ifdef SYNC_BANKED_RAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic        wr_par_flip = 1'b0;
  logic        rd_en = 1'b0;
  logic [5:0]  rd_addr = '0;

  logic [31:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid, a_par_err, b_par_err, a_busy, b_busy;

  sync_banked_ram #(.DATA_W(32), .DEPTH(64), .ADDR_W(6), .RD_PIPE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .wr_par_flip(wr_par_flip), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .par_err(a_par_err), .busy(a_busy));

  sync_banked_ram #(.DATA_W(32), .DEPTH(48), .ADDR_W(6), .RD_PIPE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .wr_par_flip(wr_par_flip), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .par_err(b_par_err), .busy(b_busy));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory contents, per-byte "parity poisoned" flags, remaining clear cycles,
  // and a queue of expected read results tagged with the cycle they must appear.
  typedef struct { int due; logic [31:0] data; bit err; } exp_t;

  logic [31:0] m_mem [2][64];
  bit   [3:0]  m_bad [2][64];
  int          busy_left [2];
  logic [31:0] last_d [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          cyc = 0;

  function automatic int dep(input int k);
    return (k == 0) ? 64 : 48;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      busy_left[k] = dep(k);
      last_d[k]    = '0;
      for (int a = 0; a < 64; a++) begin
        m_mem[k][a] = '0;
        m_bad[k][a] = '0;
      end
    end
    q0.delete();
    q1.delete();
  endfunction

  task automatic compare_outputs();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] d;
      logic        v, e, b, ev, ee;
      logic [31:0] ed;
      exp_t        r;
      d  = (k == 0) ? a_rd_data  : b_rd_data;
      v  = (k == 0) ? a_rd_valid : b_rd_valid;
      e  = (k == 0) ? a_par_err  : b_par_err;
      b  = (k == 0) ? a_busy     : b_busy;
      ev = 1'b0;
      ee = 1'b0;
      if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin
        r = q0.pop_front(); ev = 1'b1;
      end else if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin
        r = q1.pop_front(); ev = 1'b1;
      end
      if (ev) begin
        last_d[k] = r.data;
        ee = r.err;
      end
      ed = last_d[k];
      check($sformatf("busy[%0d]@%0d", k, cyc), {31'd0, b}, {31'd0, (!rst_n || busy_left[k] > 0)});
      check($sformatf("rd_valid[%0d]@%0d", k, cyc), {31'd0, v}, {31'd0, ev});
      check($sformatf("rd_data[%0d]@%0d", k, cyc), d, ed);
      if (ev) check($sformatf("par_err[%0d]@%0d", k, cyc), {31'd0, e}, {31'd0, ee});
    end
  endtask

  // Apply the current inputs to the model for the coming edge, clock once, then compare.
  task automatic step();
    exp_t        r;
    logic [31:0] d;
    bit   [3:0]  bad;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (busy_left[k] > 0) begin
          busy_left[k]--;
        end else begin
          if (rd_en) begin
            r.due = cyc + lat(k);
            r.data = '0;
            r.err = 1'b0;
            if (int'(rd_addr) < dep(k)) begin
              d   = m_mem[k][rd_addr];
              bad = m_bad[k][rd_addr];
              if (wr_en && wr_addr == rd_addr)
                for (int i = 0; i < 4; i++)
                  if (wr_be[i]) begin
                    d[8*i +: 8] = wr_data[8*i +: 8];
                    bad[i] = wr_par_flip;
                  end
              r.data = d;
              r.err  = PAR && (|bad);
            end
            if (k == 0) q0.push_back(r); else q1.push_back(r);
          end
          if (wr_en && int'(wr_addr) < dep(k))
            for (int i = 0; i < 4; i++)
              if (wr_be[i]) begin
                m_mem[k][wr_addr][8*i +: 8] = wr_data[8*i +: 8];
                m_bad[k][wr_addr][i] = wr_par_flip;
              end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    compare_outputs();
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; wr_be = '0; wr_par_flip = 1'b0;
  endtask

  task automatic reset_values_check(input string tag);
    check({tag, " a_rd_valid"}, {31'd0, a_rd_valid}, 32'd0);
    check({tag, " b_rd_valid"}, {31'd0, b_rd_valid}, 32'd0);
    check({tag, " a_rd_data"}, a_rd_data, 32'd0);
    check({tag, " b_rd_data"}, b_rd_data, 32'd0);
    check({tag, " a_par_err"}, {31'd0, a_par_err}, 32'd0);
    check({tag, " b_par_err"}, {31'd0, b_par_err}, 32'd0);
    check({tag, " a_busy"}, {31'd0, a_busy}, 32'd1);
    check({tag, " b_busy"}, {31'd0, b_busy}, 32'd1);
  endtask

  // Called right after rst_n rises: counts busy cycles while hammering the ports to show they are ignored.
  task automatic clear_check(input string tag);
    int cnt_a, cnt_b, vseen;
    cnt_a = a_busy ? 1 : 0;
    cnt_b = b_busy ? 1 : 0;
    vseen = 0;
    for (int i = 0; i < 80; i++) begin
      if (i < 40) begin
        wr_en = 1'b1; rd_en = 1'b1; wr_be = 4'hF; wr_par_flip = 1'b1;
        wr_addr = 6'($urandom_range(0, 63)); rd_addr = 6'($urandom_range(0, 63));
        wr_data = $urandom;
      end else begin
        idle();
      end
      step();
      if (a_busy) cnt_a++;
      if (b_busy) cnt_b++;
      if (a_rd_valid || b_rd_valid) vseen++;
    end
    check({tag, " busy cycles a"}, cnt_a, 32'd64);
    check({tag, " busy cycles b"}, cnt_b, 32'd48);
    check({tag, " rd_valid during clear"}, vseen, 32'd0);
  endtask

  task automatic read_sweep();
    for (int a = 0; a < 64; a++) begin
      idle();
      rd_en = 1'b1;
      rd_addr = 6'(a);
      step();
    end
    idle();
    step();
  endtask

  typedef struct {
    logic we; logic [5:0] wa; logic [3:0] be; logic [31:0] wd; logic flip;
    logic re; logic [5:0] ra;
    logic ev; logic [31:0] ed; logic ee;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [5:0] wa, input logic [3:0] be,
                              input logic [31:0] wd, input logic flip, input logic re,
                              input logic [5:0] ra, input logic ev, input logic [31:0] ed,
                              input logic ee);
    vec_t v;
    v.we = we; v.wa = wa; v.be = be; v.wd = wd; v.flip = flip;
    v.re = re; v.ra = ra; v.ev = ev; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  vec_t vq [$];

  initial begin
    // Vectors describe the latency-1, depth-64 instance; rd_data holds between reads.
    vq.push_back(mk(1'b1, 6'd5,  4'hF, 32'hAABBCCDD, 1'b0, 1'b0, 6'd0, 1'b0, 32'h00000000, 1'b0));
    vq.push_back(mk(1'b1, 6'd5,  4'h5, 32'h11223344, 1'b0, 1'b0, 6'd0, 1'b0, 32'h00000000, 1'b0));
    vq.push_back(mk(1'b0, 6'd0,  4'h0, 32'h00000000, 1'b0, 1'b1, 6'd5, 1'b1, 32'hAA22CC44, 1'b0));
    vq.push_back(mk(1'b1, 6'd7,  4'hF, 32'h01020304, 1'b0, 1'b0, 6'd0, 1'b0, 32'hAA22CC44, 1'b0));
    vq.push_back(mk(1'b1, 6'd7,  4'h3, 32'hDEADBEEF, 1'b0, 1'b1, 6'd7, 1'b1, 32'h0102BEEF, 1'b0));
    vq.push_back(mk(1'b0, 6'd0,  4'h0, 32'h00000000, 1'b0, 1'b1, 6'd7, 1'b1, 32'h0102BEEF, 1'b0));
    vq.push_back(mk(1'b1, 6'd9,  4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 6'd5, 1'b1, 32'hAA22CC44, 1'b0));
    vq.push_back(mk(1'b0, 6'd0,  4'h0, 32'h00000000, 1'b0, 1'b1, 6'd9, 1'b1, 32'hCAFEF00D, 1'b0));
    vq.push_back(mk(1'b1, 6'd9,  4'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 6'd9, 1'b1, 32'hCAFEF00D, 1'b0));
    vq.push_back(mk(1'b1, 6'd2,  4'hF, 32'h5A5A5A5A, 1'b0, 1'b0, 6'd0, 1'b0, 32'hCAFEF00D, 1'b0));
    vq.push_back(mk(1'b1, 6'd50, 4'hF, 32'h12345678, 1'b0, 1'b0, 6'd0, 1'b0, 32'hCAFEF00D, 1'b0));
    vq.push_back(mk(1'b0, 6'd0,  4'h0, 32'h00000000, 1'b0, 1'b1, 6'd50, 1'b1, 32'h12345678, 1'b0));
    vq.push_back(mk(1'b0, 6'd0,  4'h0, 32'h00000000, 1'b0, 1'b1, 6'd2, 1'b1, 32'h5A5A5A5A, 1'b0));
    vq.push_back(mk(1'b1, 6'd3,  4'hF, 32'h000000FF, 1'b1, 1'b0, 6'd0, 1'b0, 32'h5A5A5A5A, 1'b0));
    vq.push_back(mk(1'b0, 6'd0,  4'h0, 32'h00000000, 1'b0, 1'b1, 6'd3, 1'b1, 32'h000000FF, PAR));
    vq.push_back(mk(1'b1, 6'd3,  4'hF, 32'h000000FF, 1'b0, 1'b0, 6'd0, 1'b0, 32'h000000FF, 1'b0));
    vq.push_back(mk(1'b0, 6'd0,  4'h0, 32'h00000000, 1'b0, 1'b1, 6'd3, 1'b1, 32'h000000FF, 1'b0));

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_values_check("por");
    rst_n = 1'b1;
    clear_check("por");
    read_sweep();

    for (int i = 0; i < vq.size(); i++) begin
      wr_en = vq[i].we; wr_addr = vq[i].wa; wr_be = vq[i].be; wr_data = vq[i].wd;
      wr_par_flip = vq[i].flip; rd_en = vq[i].re; rd_addr = vq[i].ra;
      step();
      check($sformatf("vec%0d rd_valid", i), {31'd0, a_rd_valid}, {31'd0, vq[i].ev});
      check($sformatf("vec%0d rd_data", i), a_rd_data, vq[i].ed);
      if (vq[i].ev) check($sformatf("vec%0d par_err", i), {31'd0, a_par_err}, {31'd0, vq[i].ee});
    end

    // Depth-48 instance: address 50 reads as zero at latency 2 and aliasing word 2 keeps its data.
    idle(); rd_en = 1'b1; rd_addr = 6'd50; step();
    idle(); step();
    check("oor b rd_valid", {31'd0, b_rd_valid}, 32'd1);
    check("oor b rd_data", b_rd_data, 32'h0);
    check("oor b par_err", {31'd0, b_par_err}, 32'd0);
    idle(); rd_en = 1'b1; rd_addr = 6'd2; step();
    idle(); step();
    check("alias b rd_data", b_rd_data, 32'h5A5A5A5A);

    for (int i = 0; i < 400; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      rd_en = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 6'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) rd_addr = 6'($urandom_range(40, 63));
      wr_be = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      wr_par_flip = ($urandom_range(0, 7) == 0);
      step();
    end

    // Reset with reads in flight: nothing may emerge afterwards and the sweep restarts.
    idle(); rd_en = 1'b1; rd_addr = 6'd5; step();
    rd_addr = 6'd9; step();
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_values_check("mid");
    idle();
    step();
    rst_n = 1'b1;
    clear_check("mid");
    read_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_banked_ram.md
SYNC_BANKED_RAM -- requirements
Module: sync_banked_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 64, number of words.
REQ-003 SHALL have parameter ADDR_W, default 6, address width; must satisfy 2**ADDR_W >= DEPTH.
REQ-004 SHALL have parameter RD_PIPE, default 1, read latency in cycles; legal values are 1 and 2 only.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1 bit, write request.
REQ-008 SHALL have port wr_addr, input, ADDR_W bits, write address.
REQ-009 SHALL have port wr_be, input, DATA_W/8 bits, byte enables; bit i selects wr_data[8i+7:8i].
REQ-010 SHALL have port wr_data, input, DATA_W bits, write data.
REQ-011 SHALL have port wr_par_flip, input, 1 bit, parity-error injection for written bytes.
REQ-012 SHALL have port rd_en, input, 1 bit, read request.
REQ-013 SHALL have port rd_addr, input, ADDR_W bits, read address.
REQ-014 SHALL have port rd_data, output, DATA_W bits, read data.
REQ-015 SHALL have port rd_valid, output, 1 bit, one-cycle qualifier for rd_data.
REQ-016 SHALL have port par_err, output, 1 bit, parity error flag; qualified by rd_valid.
REQ-017 SHALL have port busy, output, 1 bit, high while the post-reset clear sweep runs.

Function
REQ-018 SHALL use a two-state FSM: CLEAR, READY; rst_n low forces CLEAR with sweep counter 0.
REQ-019 In CLEAR, the block SHALL write all-zero data (and correct parity) to mem[counter] each cycle and increment the counter; after writing DEPTH-1 it SHALL enter READY, so CLEAR lasts exactly DEPTH cycles.
REQ-020 busy SHALL be 1 exactly while in CLEAR; wr_en and rd_en SHALL be ignored in CLEAR (no write, no rd_valid).
REQ-021 In READY, wr_en high at a clock edge SHALL update only the bytes of mem[wr_addr] whose wr_be bit is 1; wr_be all-zero SHALL leave memory unchanged.
REQ-022 In READY, rd_en high at edge N SHALL produce rd_valid=1 and rd_data at edge N+RD_PIPE, for exactly one cycle per accepted read; back-to-back reads SHALL sustain one result per cycle.
REQ-023 When rd_valid is 0, rd_data SHALL hold its last value.
REQ-024 A same-cycle read and write to the same address SHALL be write-first: enabled bytes return wr_data, the other bytes return the stored data.
REQ-025 Addresses >= DEPTH SHALL be out of range: writes dropped; reads complete normally with rd_data all-zero and par_err 0.
REQ-026 Simultaneous read and write to different addresses SHALL both complete with no interaction.

Reset
REQ-027 Asserting rst_n low SHALL immediately force rd_data=0, rd_valid=0, par_err=0, busy=1, and flush all in-flight reads.
REQ-028 Reset mid-operation SHALL drop pending reads and restart the full DEPTH-cycle clear sweep from address 0 after rst_n deasserts.

Configuration
REQ-029 Macro SYNC_BANKED_RAM_PARITY_EN SHALL compile in one even-parity bit per byte, stored alongside the data.
REQ-030 With the macro defined, a write with wr_par_flip=1 SHALL store inverted parity for the enabled bytes.
REQ-031 With the macro defined, each read SHALL recompute parity, and par_err SHALL be 1 with rd_valid if any byte mismatches; write-first bypassed bytes use their fresh parity.
REQ-032 Without the macro, no parity storage SHALL exist, par_err SHALL be constant 0, and wr_par_flip SHALL be ignored.

Verification
REQ-033 Release reset -> busy=1 for exactly 64 cycles; then read every address -> all data 0x00000000, par_err=0.
REQ-034 Write 0xAABBCCDD to addr 5 with wr_be=4'b1111, then with wr_be=4'b0101 write 0x11223344 -> reading addr 5 returns 0xAA22CC44 at latency RD_PIPE.
REQ-035 Same-cycle write 0xDEADBEEF (wr_be=4'b0011) and read at addr 7, holding 0x01020304 -> rd_data=0x0102BEEF.
REQ-036 rst_n low for one cycle while two reads are in flight with RD_PIPE=2 -> no rd_valid afterwards, and busy=1 again for 64 cycles.
REQ-037 With SYNC_BANKED_RAM_PARITY_EN defined: write addr 3 with wr_par_flip=1, then read addr 3 -> par_err=1 with rd_valid; rewrite with wr_par_flip=0 -> par_err=0.
REQ-038 With DEPTH=48, ADDR_W=6: write to addr 50, then read addr 50 -> rd_valid=1 with rd_data=0; mem[50 mod 48] remains unchanged.
